stall_controller: RTL and testbench

STALL_CONTROLLER -- requirements
Module: stall_controller

---
 rtl/stall_controller_pkg.sv | 38 +++
 rtl/md_sequencer.sv | 72 +++++++
 rtl/stall_controller.sv | 112 +++++++++++
 tb/tb_stall_controller.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/stall_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stall_controller_pkg
// Description : Processor constants shared by the hazard, bypass and decode
//               logic: instruction field opcodes, ALU op codes, multdiv
//               sequencer state encodings and counter limits.
// Revision    : 1.0 - initial release
// ============================================================================
package stall_controller_pkg;

    // Primary opcodes, ir[31:27]
    localparam logic [4:0] c_OP_RTYPE = 5'b00000;
    localparam logic [4:0] c_OP_BNE   = 5'b00010;
    localparam logic [4:0] c_OP_JR    = 5'b00100;
    localparam logic [4:0] c_OP_BLT   = 5'b00110;
    localparam logic [4:0] c_OP_SW    = 5'b00111;
    localparam logic [4:0] c_OP_LW    = 5'b01000;

    // R-type ALU op codes, ir[6:2]
    localparam logic [4:0] c_ALU_MUL  = 5'b00110;
    localparam logic [4:0] c_ALU_DIV  = 5'b00111;

    // Multdiv sequencer state encoding
    localparam int         C_STATE_W  = 1;
    localparam logic [C_STATE_W-1:0] c_ST_IDLE = 1'b0;
    localparam logic [C_STATE_W-1:0] c_ST_BUSY = 1'b1;

    // Busy-cycle counter
    localparam int         C_CYCLES_W   = 6;
    localparam logic [C_CYCLES_W-1:0] c_CYCLES_MAX = 6'd63;

    // True when an opcode/ALU-op pair is a multiply or divide
    function automatic logic is_muldiv(input logic [4:0] opcode, input logic [4:0] aluop);
        return (opcode == c_OP_RTYPE) && ((aluop == c_ALU_MUL) || (aluop == c_ALU_DIV));
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : md_sequencer
// Description : IDLE/BUSY sequencer for the iterative multdiv unit plus the
//               saturating count of cycles spent waiting in BUSY.
//   clk          in  clock, rising edge
//   rst          in  synchronous active-high reset
//   i_start_req  in  DX holds a mul/div that may start this cycle
//   i_md_ready   in  multdiv result valid
//   o_start      out start accepted this cycle (IDLE and requested)
//   o_busy       out sequencer is in BUSY
//   o_hold       out pipeline must hold FD/DX and bubble XM
//   o_done       out result cycle (BUSY with md_ready)
//   o_cycles     out cycles spent in BUSY, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module md_sequencer
    import stall_controller_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start_req,
    input  logic                  i_md_ready,
    output logic                  o_start,
    output logic                  o_busy,
    output logic                  o_hold,
    output logic                  o_done,
    output logic [C_CYCLES_W-1:0] o_cycles
);

    logic [C_STATE_W-1:0]  r_state;
    logic [C_CYCLES_W-1:0] r_cycles;

    logic w_idle;
    logic w_busy;

    assign w_idle   = (r_state == c_ST_IDLE);
    assign w_busy   = (r_state == c_ST_BUSY);

    assign o_start  = w_idle & i_start_req;
    assign o_busy   = w_busy;
    assign o_done   = w_busy & i_md_ready;
    // The start cycle itself holds too: the mul/div must stay in DX.
    assign o_hold   = o_start | (w_busy & ~i_md_ready);
    assign o_cycles = r_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_cycles <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (i_start_req) begin
                        r_state  <= c_ST_BUSY;
                        r_cycles <= '0;
                    end
                end
                c_ST_BUSY: begin
                    if (i_md_ready) begin
                        r_state <= c_ST_IDLE;
                    end else if (r_cycles != c_CYCLES_MAX) begin
                        r_cycles <= r_cycles + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : stall_controller
// Description : Pipeline hazard controller: branch flush, load-use stall and
//               multdiv start/hold/result steering.
//   clock, reset            pipeline clock / synchronous active-high reset
//   fd_ir, dx_ir            instructions in the FD and DX latches
//   branch_taken            X-stage branch/jump taken this cycle
//   md_ready, md_exception  multdiv result valid / overflow or div-by-zero
//   stall_fd, stall_dx      hold PC+FD / hold DX
//   bubble_dx, bubble_xm    load nop into DX / XM at the next edge
//   flush_fd                load nop into FD at the next edge
//   ctrl_mult, ctrl_div     one-cycle multdiv start pulses
//   md_result_sel, md_ovf   XM takes multdiv result / its overflow flag
//   md_busy, md_cycles      sequencer busy / busy-cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module stall_controller
    import stall_controller_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           fd_ir,
    input  logic [31:0]           dx_ir,
    input  logic                  branch_taken,
    input  logic                  md_ready,
    input  logic                  md_exception,
    output logic                  stall_fd,
    output logic                  stall_dx,
    output logic                  bubble_dx,
    output logic                  bubble_xm,
    output logic                  flush_fd,
    output logic                  ctrl_mult,
    output logic                  ctrl_div,
    output logic                  md_result_sel,
    output logic                  md_ovf,
    output logic                  md_busy,
    output logic [C_CYCLES_W-1:0] md_cycles
);

    // Instruction fields
    logic [4:0] w_fd_op, w_fd_rd, w_fd_rs, w_fd_rt;
    logic [4:0] w_dx_op, w_dx_rd, w_dx_alu;

    assign w_fd_op  = fd_ir[31:27];
    assign w_fd_rd  = fd_ir[26:22];
    assign w_fd_rs  = fd_ir[21:17];
    assign w_fd_rt  = fd_ir[16:12];
    assign w_dx_op  = dx_ir[31:27];
    assign w_dx_rd  = dx_ir[26:22];
    assign w_dx_alu = dx_ir[6:2];

    // Immediate/shamt fields play no part in hazard detection.
    logic w_unused;
    assign w_unused = &{1'b0, fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

    logic w_run;
    assign w_run = ~reset;

    // Multdiv sequencing
    logic                  w_start_req;
    logic                  w_start;
    logic                  w_busy;
    logic                  w_hold;
    logic                  w_done;
    logic [C_CYCLES_W-1:0] w_cycles;

    // A taken branch squashes DX, so a mul/div there must not start.
    assign w_start_req = is_muldiv(w_dx_op, w_dx_alu) & ~branch_taken;

    md_sequencer u_md_sequencer (
        .clk         (clock),
        .rst         (reset),
        .i_start_req (w_start_req),
        .i_md_ready  (md_ready),
        .o_start     (w_start),
        .o_busy      (w_busy),
        .o_hold      (w_hold),
        .o_done      (w_done),
        .o_cycles    (w_cycles)
    );

    // Load-use: FD consumes the register a DX load is about to write.
    // A store's data register (rd) is bypassed W->M and does not count.
    logic w_fd_uses_rd;
    logic w_reads_rs, w_reads_rt, w_reads_rd;
    logic w_load_use;

    assign w_fd_uses_rd = (w_fd_op == c_OP_BNE) || (w_fd_op == c_OP_BLT) || (w_fd_op == c_OP_JR);
    assign w_reads_rs   = (w_fd_rs == w_dx_rd);
    assign w_reads_rt   = (w_fd_op == c_OP_RTYPE) && (w_fd_rt == w_dx_rd);
    assign w_reads_rd   = w_fd_uses_rd && (w_fd_rd == w_dx_rd);

    assign w_load_use = ~w_busy & ~branch_taken & ~w_start
                      & (w_dx_op == c_OP_LW) & (w_dx_rd != 5'd0)
                      & (w_reads_rs | w_reads_rt | w_reads_rd);

    // Outputs: all forced low while reset is high, branch flush wins over stalls.
    assign flush_fd      = w_run & branch_taken;
    assign bubble_dx     = w_run & (branch_taken | w_load_use);
    assign stall_fd      = w_run & ~branch_taken & (w_hold | w_load_use);
    assign stall_dx      = w_run & ~branch_taken & w_hold;
    assign bubble_xm     = w_run & ~branch_taken & w_hold;
    assign ctrl_mult     = w_run & w_start & (w_dx_alu == c_ALU_MUL);
    assign ctrl_div      = w_run & w_start & (w_dx_alu == c_ALU_DIV);
    assign md_result_sel = w_run & w_done;
    assign md_ovf        = w_run & w_done & md_exception;
    assign md_busy       = w_run & w_busy;
    assign md_cycles     = w_run ? w_cycles : '0;

endmodule
`default_nettype wire

// File: tb/tb_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_stall_controller
// Description : Directed self-checking bench for stall_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stall_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fd_ir = '0;
    logic [31:0] dx_ir = '0;
    logic        branch_taken = 1'b0;
    logic        md_ready = 1'b0;
    logic        md_exception = 1'b0;
    logic        stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd;
    logic        ctrl_mult, ctrl_div, md_result_sel, md_ovf, md_busy;
    logic [5:0]  md_cycles;

    int n_checks = 0;
    int n_pass   = 0;
    int stalls   = 0;

    always #5 clock = ~clock;

    stall_controller dut (
        .clock         (clock),
        .reset         (reset),
        .fd_ir         (fd_ir),
        .dx_ir         (dx_ir),
        .branch_taken  (branch_taken),
        .md_ready      (md_ready),
        .md_exception  (md_exception),
        .stall_fd      (stall_fd),
        .stall_dx      (stall_dx),
        .bubble_dx     (bubble_dx),
        .bubble_xm     (bubble_xm),
        .flush_fd      (flush_fd),
        .ctrl_mult     (ctrl_mult),
        .ctrl_div      (ctrl_div),
        .md_result_sel (md_result_sel),
        .md_ovf        (md_ovf),
        .md_busy       (md_busy),
        .md_cycles     (md_cycles)
    );

    // {stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd,
    //  ctrl_mult, ctrl_div, md_result_sel, md_ovf, md_busy}
    logic [9:0] w_outs;
    assign w_outs = {stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd,
                     ctrl_mult, ctrl_div, md_result_sel, md_ovf, md_busy};

    localparam logic [9:0] c_O_NONE  = 10'b0000000000;
    localparam logic [9:0] c_O_MULST = 10'b1101010000;
    localparam logic [9:0] c_O_DIVST = 10'b1101001000;
    localparam logic [9:0] c_O_WAIT  = 10'b1101000001;
    localparam logic [9:0] c_O_DONE  = 10'b0000000101;
    localparam logic [9:0] c_O_DOVF  = 10'b0000000111;
    localparam logic [9:0] c_O_LU    = 10'b1010000000;
    localparam logic [9:0] c_O_FLUSH = 10'b0010100000;
    localparam logic [31:0] c_NOP    = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] alu);
        return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    initial begin
        logic [31:0] mul_r3, div_r3, lw_r5, lw_r0;
        mul_r3 = rtype(5'd3, 5'd1, 5'd2, 5'b00110);
        div_r3 = rtype(5'd3, 5'd1, 5'd2, 5'b00111);
        lw_r5  = itype(5'b01000, 5'd5, 5'd1, 17'd0);
        lw_r0  = itype(5'b01000, 5'd0, 5'd1, 17'd0);

        // Reset with hazards present on the inputs: everything held low
        dx_ir = mul_r3; branch_taken = 1'b1; md_ready = 1'b1;
        #2;
        check("reset_outs", w_outs, c_O_NONE);
        check("reset_cycles", md_cycles, 0);
        tick;
        tick;
        dx_ir = c_NOP; branch_taken = 1'b0; md_ready = 1'b0;
        reset = 1'b0;
        #1;
        check("idle_outs", w_outs, c_O_NONE);
        tick;

        // mul with md_ready after four waiting BUSY cycles
        dx_ir = mul_r3;
        #1;
        check("mul_start", w_outs, c_O_MULST);
        stalls = int'(stall_fd);
        tick;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check("mul_wait", w_outs, c_O_WAIT);
            check("mul_wait_cycles", md_cycles, k - 1);
            stalls += int'(stall_fd);
            tick;
        end
        md_ready = 1'b1;
        #1;
        check("mul_done", w_outs, c_O_DONE);
        check("mul_done_cycles", md_cycles, 4);
        stalls += int'(stall_fd);
        tick;
        check("mul_stall_len", stalls, 5);
        md_ready = 1'b0; dx_ir = c_NOP;
        #1;
        check("mul_after", w_outs, c_O_NONE);
        check("mul_after_cycles", md_cycles, 4);
        tick;

        // Load-use: rs, rt, store base, branch rd; store data and I-type rt bits do not stall
        dx_ir = lw_r5; fd_ir = rtype(5'd6, 5'd5, 5'd2, 5'b00000);
        #1;
        check("lu_rs", w_outs, c_O_LU);
        tick;
        dx_ir = c_NOP;
        #1;
        check("lu_one_cycle", w_outs, c_O_NONE);
        dx_ir = lw_r5; fd_ir = rtype(5'd6, 5'd2, 5'd5, 5'b00000);
        #1;
        check("lu_rt", w_outs, c_O_LU);
        fd_ir = itype(5'b00111, 5'd5, 5'd2, 17'd0);
        #1;
        check("lu_sw_data", w_outs, c_O_NONE);
        fd_ir = itype(5'b00111, 5'd7, 5'd5, 17'd0);
        #1;
        check("lu_sw_base", w_outs, c_O_LU);
        fd_ir = itype(5'b00010, 5'd5, 5'd1, 17'd4);
        #1;
        check("lu_bne_rd", w_outs, c_O_LU);
        fd_ir = itype(5'b00101, 5'd6, 5'd1, 17'h05000);
        #1;
        check("lu_itype_rt", w_outs, c_O_NONE);
        dx_ir = lw_r0; fd_ir = rtype(5'd6, 5'd0, 5'd0, 5'b00000);
        #1;
        check("lu_r0", w_outs, c_O_NONE);
        dx_ir = lw_r5; fd_ir = rtype(5'd6, 5'd5, 5'd2, 5'b00000); branch_taken = 1'b1;
        #1;
        check("lu_flushed", w_outs, c_O_FLUSH);
        tick;

        // div squashed by a taken branch: no start, FSM stays IDLE
        dx_ir = div_r3; fd_ir = c_NOP; branch_taken = 1'b1;
        #1;
        check("div_flush", w_outs, c_O_FLUSH);
        tick;
        dx_ir = c_NOP; branch_taken = 1'b0;
        #1;
        check("div_flush_idle", w_outs, c_O_NONE);
        tick;

        // Reset in the third BUSY cycle, then a stray md_ready
        dx_ir = mul_r3;
        #1;
        check("rst_mul_start", w_outs, c_O_MULST);
        tick;
        tick;
        tick;
        reset = 1'b1;
        #1;
        check("rst_busy_outs", w_outs, c_O_NONE);
        check("rst_busy_cycles", md_cycles, 0);
        tick;
        reset = 1'b0; dx_ir = c_NOP; md_ready = 1'b1;
        #1;
        check("rst_stray_ready", w_outs, c_O_NONE);
        tick;
        md_ready = 1'b0;

        // Saturation with md_ready withheld for 70 cycles, then overflow result
        dx_ir = div_r3;
        #1;
        check("sat_div_start", w_outs, c_O_DIVST);
        tick;
        for (int k = 1; k <= 70; k++) begin
            #1;
            if (k == 63) check("sat_cycles_62", md_cycles, 62);
            if (k == 64) check("sat_cycles_63", md_cycles, 63);
            tick;
        end
        #1;
        check("sat_wait", w_outs, c_O_WAIT);
        check("sat_hold_63", md_cycles, 63);
        md_ready = 1'b1; md_exception = 1'b1;
        #1;
        check("ovf_done", w_outs, c_O_DOVF);
        tick;
        dx_ir = c_NOP;
        #1;
        check("ovf_single", w_outs, c_O_NONE);
        tick;
        md_ready = 1'b0; md_exception = 1'b0;

        // Back-to-back mul: result cycle then immediate restart
        dx_ir = mul_r3;
        #1;
        check("b2b_start1", w_outs, c_O_MULST);
        tick;
        #1;
        check("b2b_wait", w_outs, c_O_WAIT);
        tick;
        md_ready = 1'b1;
        #1;
        check("b2b_done", w_outs, c_O_DONE);
        tick;
        md_ready = 1'b0;
        #1;
        check("b2b_start2", w_outs, c_O_MULST);
        check("b2b_cycles_clr_pending", md_cycles, 1);
        tick;
        #1;
        check("b2b_cycles_clr", md_cycles, 0);
        check("b2b_wait2", w_outs, c_O_WAIT);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
